// File: rtl/mem_bus_arbiter_n_if.sv
// Bundles the client request/response lanes and the tagged main-memory port of mem_bus_arbiter_n.
// slave is the arbiter's view; master is the view of the clients plus the memory model.
interface mem_bus_arbiter_n_if #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned TAG_W       = 4
);
   logic [NUM_CLIENTS-1:0][1:0]        c_command;
   logic [NUM_CLIENTS-1:0][ADDR_W-1:0] c_address;
   logic [NUM_CLIENTS-1:0][DATA_W-1:0] c_wdata;
   logic [NUM_CLIENTS-1:0][TAG_W-1:0]  c_response;
   logic [NUM_CLIENTS-1:0][TAG_W-1:0]  c_tag;
   logic [NUM_CLIENTS-1:0][DATA_W-1:0] c_rdata;
   logic [TAG_W-1:0]                   mem2proc_response;
   logic [TAG_W-1:0]                   mem2proc_tag;
   logic [DATA_W-1:0]                  mem2proc_rdata;
   logic [1:0]                         proc2mem_command;
   logic [ADDR_W-1:0]                  proc2mem_address;
   logic [DATA_W-1:0]                  proc2mem_wdata;
   logic [TAG_W:0]                     outstanding;

   modport slave (
      input  c_command, c_address, c_wdata,
      input  mem2proc_response, mem2proc_tag, mem2proc_rdata,
      output c_response, c_tag, c_rdata,
      output proc2mem_command, proc2mem_address, proc2mem_wdata,
      output outstanding
   );

   modport master (
      output c_command, c_address, c_wdata,
      output mem2proc_response, mem2proc_tag, mem2proc_rdata,
      input  c_response, c_tag, c_rdata,
      input  proc2mem_command, proc2mem_address, proc2mem_wdata,
      input  outstanding
   );
endinterface

// File: rtl/mem_bus_arbiter_n.sv
// N-client arbiter onto one tagged memory port, tracking outstanding loads by tag.
// Define MEM_ARB_FIXED_PRIO_EN for lowest-index-wins selection instead of round-robin.
module mem_bus_arbiter_n #(
   parameter int unsigned NUM_CLIENTS = 2,
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned TAG_W       = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_bus_arbiter_n_if.slave   bus
);
   localparam int unsigned GNT_W    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
   localparam int unsigned NUM_TAGS = 1 << TAG_W;
   localparam int unsigned OUT_W    = TAG_W + 1;

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_LOAD = 2'd1;

   typedef enum logic {S_IDLE, S_ISSUE} state_e;

   state_e             state_q, state_d;
   logic [GNT_W-1:0]   gnt_q, gnt_d;
   logic [NUM_TAGS-1:0] valid_q, valid_d;
   logic [GNT_W-1:0]   owner_q [NUM_TAGS];
   logic [GNT_W-1:0]   owner_d [NUM_TAGS];
   logic [OUT_W-1:0]   outstanding_q, outstanding_d;

   logic               req_any;
   logic [GNT_W-1:0]   sel_idx, cand, rr_base;
   logic               accept, abort, alloc, ret_hit;
   logic [ADDR_W-1:0]  issue_addr;
   logic [DATA_W-1:0]  issue_wdata;
   logic [DATA_W-1:0]  ret_data;

`ifdef MEM_ARB_FIXED_PRIO_EN
   assign rr_base = '0;
`else
   logic [GNT_W-1:0]   rr_q, rr_d;

   assign rr_base = rr_q;

   // Pointer moves past the winner only on an accepted command.
   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = (gnt_q == GNT_W'(NUM_CLIENTS - 1)) ? '0 : gnt_q + GNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) rr_q <= '0;
      else       rr_q <= rr_d;
   end
`endif

   // First requester found searching upward from rr_base, wrapping.
   always_comb begin
      req_any = 1'b0;
      sel_idx = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
         cand = GNT_W'((32'(rr_base) + i) % NUM_CLIENTS);
         if (!req_any && bus.c_command[cand] != BUS_NONE) begin
            req_any = 1'b1;
            sel_idx = cand;
         end
      end
   end

   assign accept   = (state_q == S_ISSUE) && (bus.mem2proc_response != '0);
   assign abort    = (state_q == S_ISSUE) && !accept && (bus.c_command[gnt_q] == BUS_NONE);
   assign alloc    = accept && (bus.c_command[gnt_q] == BUS_LOAD);
   assign ret_hit  = (bus.mem2proc_tag != '0) && valid_q[bus.mem2proc_tag];
   assign issue_addr  = bus.c_address[gnt_q];
   assign issue_wdata = bus.c_wdata[gnt_q];
   assign ret_data    = bus.mem2proc_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         gnt_q         <= '0;
         valid_q       <= '0;
         outstanding_q <= '0;
         for (int unsigned t = 0; t < NUM_TAGS; t++) owner_q[t] <= '0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         valid_q       <= valid_d;
         outstanding_q <= outstanding_d;
         for (int unsigned t = 0; t < NUM_TAGS; t++) owner_q[t] <= owner_d[t];
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_any) begin
               state_d = S_ISSUE;
               gnt_d   = sel_idx;
            end
         end
         S_ISSUE: begin
            if (accept || abort) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Return retires the entry before a same-cycle allocation reclaims it.
   always_comb begin
      valid_d = valid_q;
      for (int unsigned t = 0; t < NUM_TAGS; t++) owner_d[t] = owner_q[t];
      if (ret_hit) valid_d[bus.mem2proc_tag] = 1'b0;
      if (alloc) begin
         valid_d[bus.mem2proc_response] = 1'b1;
         owner_d[bus.mem2proc_response] = gnt_q;
      end
      valid_d[0]    = 1'b0;
      outstanding_d = outstanding_q + OUT_W'(alloc) - OUT_W'(ret_hit);
   end

   always_comb begin
      bus.proc2mem_command = BUS_NONE;
      bus.proc2mem_address = '0;
      bus.proc2mem_wdata   = '0;
      bus.c_response       = '0;
      if (state_q == S_ISSUE) begin
         bus.proc2mem_command  = bus.c_command[gnt_q];
         bus.proc2mem_address  = issue_addr;
         bus.proc2mem_wdata    = issue_wdata;
         bus.c_response[gnt_q] = bus.mem2proc_response;
      end
   end

   // Data return is steered by the tag table alone, in any FSM state.
   always_comb begin
      bus.c_tag   = '0;
      bus.c_rdata = '0;
      if (ret_hit) begin
         bus.c_tag[owner_q[bus.mem2proc_tag]]   = bus.mem2proc_tag;
         bus.c_rdata[owner_q[bus.mem2proc_tag]] = ret_data;
      end
   end

   assign bus.outstanding = outstanding_q;

endmodule
